uart_rx: RTL and testbench

UART receiver, the mirror of the team's 8N1 UART transmitter. It oversamples the asynchronous serial line, detects the start bit and samples each data bit at mid-bit. Each received word is presented to a downstream sink over a valid/ready handshake. Framing errors and overruns are flagged with single-cycle pulses. It sits between the board RX pin and the command/data consumer logic.

---
 rtl/uart_rx_if.sv | 24 ++
 rtl/uart_rx.sv | 171 +++++++++++++++++
 tb/tb_uart_rx.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: word handshake between the UART receiver and its sink.
//   data_to_sink    : received word, held stable while valid_to_sink is high
//   valid_to_sink   : a word is pending for the sink
//   ready_from_sink : sink takes the word on a cycle where both are high
// master = receiver side, slave = consumer side.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_to_sink;
  logic                  valid_to_sink;
  logic                  ready_from_sink;

  modport master (
    output data_to_sink,
    output valid_to_sink,
    input  ready_from_sink
  );

  modport slave (
    input  data_to_sink,
    input  valid_to_sink,
    output ready_from_sink
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver. The serial line is synchronised, the
// start bit is qualified at mid-bit, and each data bit and the stop bit are
// sampled at mid-bit. Completed words go to the sink over a valid/ready
// handshake.
// Ports:
//   clk       : system clock, rising edge
//   rstn      : asynchronous active-low reset
//   rx_sig    : serial input, asynchronous, idle high
//   sink      : uart_rx_if master (data_to_sink / valid_to_sink / ready_from_sink)
//   frame_err : 1-cycle pulse when the stop bit is sampled low
//   overrun   : 1-cycle pulse when a word completes while the previous one is pending
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000
) (
  input  logic     clk,
  input  logic     rstn,
  input  logic     rx_sig,
  uart_rx_if.master sink,
  output logic     frame_err,
  output logic     overrun
);

  localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
  localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
  localparam int CNT_W            = $clog2(PULSE_WIDTH) + 1;
  localparam int BIT_W            = $clog2(DATA_WIDTH) + 1;

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  sync1_q, rx_s_q;
  logic                  accept;

  // Two-flop synchroniser; resets to the idle line level so no false start
  // is seen when reset is released.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx_sig;
      rx_s_q  <= sync1_q;
    end
  end

  assign accept = valid_q & sink.ready_from_sink;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q & ~accept;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end

      START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!rx_s_q) begin
          state_d = DATA;
          cnt_d   = FULL_LOAD;
          bit_d   = '0;
        end else begin
          // Line went back high before mid start bit: treat as a glitch.
          state_d = IDLE;
        end
      end

      DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // LSB arrives first, so shift right and insert at the MSB.
          shift_d = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
          cnt_d   = FULL_LOAD;
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end

      STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rx_s_q) begin
          // Leaving at mid stop bit keeps half a bit of margin for the next start.
          state_d = IDLE;
          if (!valid_q || accept) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          frame_err_d = 1'b1;
          state_d     = BRK;
        end
      end

      BRK: begin
        // Hold here through a break / stuck-low line so only one error is flagged.
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign sink.data_to_sink  = data_q;
  assign sink.valid_to_sink = valid_q;
  assign frame_err          = frame_err_q;
  assign overrun            = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 1 MHz / 100 kbit/s (10 clk per bit).
module tb_uart_rx;

  localparam int PW = 10;

  logic clk    = 1'b0;
  logic rstn   = 1'b1;
  logic rx_sig = 1'b1;
  logic frame_err;
  logic overrun;

  uart_rx_if #(.DATA_WIDTH(8)) bus ();

  uart_rx #(
    .DATA_WIDTH(8),
    .BAUD_RATE (100_000),
    .CLK_FREQ  (1_000_000)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rx_sig   (rx_sig),
    .sink     (bus),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Sink-side monitor: collects accepted words and counts error pulses.
  logic [7:0] rx_q[$];
  int         acc_q[$];
  int         fe_cnt = 0;
  int         ov_cnt = 0;

  always @(negedge clk) begin
    if (rstn && bus.valid_to_sink && bus.ready_from_sink) begin
      rx_q.push_back(bus.data_to_sink);
      acc_q.push_back(cyc);
    end
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // All line tasks start and end 1 time unit after a rising edge.
  task automatic send_bit(input logic b);
    rx_sig = b;
    repeat (PW) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_sig = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, output int fall);
    fall = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  typedef struct {
    logic [7:0] d;
    int         gap;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[4];
  int         fall[4];
  int         n0, fe0, ov0, f;
  logic [7:0] got;
  int         lat;

  initial begin
    // A5 alone after idle, then 00/FF/3C back-to-back with no idle gap.
    vecs[0] = '{d: 8'hA5, gap: 20, exp: 8'hA5};
    vecs[1] = '{d: 8'h00, gap: 0,  exp: 8'h00};
    vecs[2] = '{d: 8'hFF, gap: 0,  exp: 8'hFF};
    vecs[3] = '{d: 8'h3C, gap: 0,  exp: 8'h3C};

    bus.ready_from_sink = 1'b1;

    // Reset state
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'b0, bus.valid_to_sink}, 32'd0);
    chk("rst_data", {24'b0, bus.data_to_sink}, 32'd0);
    chk("rst_frame_err", {31'b0, frame_err}, 32'd0);
    chk("rst_overrun", {31'b0, overrun}, 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    idle(10);

    // Table: single frame and back-to-back frames
    n0 = rx_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].gap > 0) idle(vecs[i].gap);
      send_frame(vecs[i].d, 1'b1, fall[i]);
    end
    idle(30);
    chk("tbl_count", rx_q.size() - n0, 32'd4);
    for (int i = 0; i < 4; i++) begin
      got = (n0 + i < rx_q.size()) ? rx_q[n0 + i] : 8'hxx;
      lat = (n0 + i < acc_q.size()) ? acc_q[n0 + i] - fall[i] : -1;
      chk($sformatf("tbl_data[%0d]", i), {24'b0, got}, {24'b0, vecs[i].exp});
      chk_rng($sformatf("tbl_latency[%0d]", i), lat, 97, 99);
    end
    chk("tbl_frame_err", fe_cnt - fe0, 32'd0);
    chk("tbl_overrun", ov_cnt - ov0, 32'd0);

    // Overrun with sink stalled
    bus.ready_from_sink = 1'b0;
    n0 = rx_q.size(); ov0 = ov_cnt; fe0 = fe_cnt;
    send_frame(8'h11, 1'b1, f);
    send_frame(8'h22, 1'b1, f);
    idle(15);
    chk("ovr_pulses", ov_cnt - ov0, 32'd1);
    chk("ovr_data_held", {24'b0, bus.data_to_sink}, 32'h11);
    chk("ovr_valid_held", {31'b0, bus.valid_to_sink}, 32'd1);
    chk("ovr_no_accept", rx_q.size() - n0, 32'd0);
    bus.ready_from_sink = 1'b1;
    @(posedge clk);
    #1;
    chk("ovr_valid_drop", {31'b0, bus.valid_to_sink}, 32'd0);
    chk("ovr_accept_count", rx_q.size() - n0, 32'd1);
    got = (n0 < rx_q.size()) ? rx_q[n0] : 8'hxx;
    chk("ovr_accept_data", {24'b0, got}, 32'h11);
    chk("ovr_frame_err", fe_cnt - fe0, 32'd0);
    idle(10);

    // Framing error, line held low, then recovery
    n0 = rx_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h55, 1'b0, f);
    rx_sig = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    idle(20);
    chk("fe_pulses", fe_cnt - fe0, 32'd1);
    chk("fe_no_word", rx_q.size() - n0, 32'd0);
    send_frame(8'h81, 1'b1, f);
    idle(20);
    chk("fe_next_count", rx_q.size() - n0, 32'd1);
    got = (n0 < rx_q.size()) ? rx_q[n0] : 8'hxx;
    chk("fe_next_data", {24'b0, got}, 32'h81);
    chk("fe_single", fe_cnt - fe0, 32'd1);
    chk("fe_overrun", ov_cnt - ov0, 32'd0);

    // Short low glitch on an idle line
    n0 = rx_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    rx_sig = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(20);
    chk("gl_no_word", rx_q.size() - n0, 32'd0);
    chk("gl_no_err", (fe_cnt - fe0) + (ov_cnt - ov0), 32'd0);
    send_frame(8'h5A, 1'b1, f);
    idle(20);
    got = (n0 < rx_q.size()) ? rx_q[n0] : 8'hxx;
    chk("gl_next_count", rx_q.size() - n0, 32'd1);
    chk("gl_next_data", {24'b0, got}, 32'h5A);

    // Reset in the middle of the data bits of 0xC3
    n0 = rx_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rx_sig = 1'b0;
    repeat (4) @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    chk("mr_valid", {31'b0, bus.valid_to_sink}, 32'd0);
    chk("mr_data", {24'b0, bus.data_to_sink}, 32'd0);
    chk("mr_frame_err", {31'b0, frame_err}, 32'd0);
    chk("mr_overrun", {31'b0, overrun}, 32'd0);
    rx_sig = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    idle(20);
    chk("mr_no_word", rx_q.size() - n0, 32'd0);
    chk("mr_no_err", (fe_cnt - fe0) + (ov_cnt - ov0), 32'd0);
    send_frame(8'h7E, 1'b1, f);
    idle(20);
    got = (n0 < rx_q.size()) ? rx_q[n0] : 8'hxx;
    chk("mr_next_count", rx_q.size() - n0, 32'd1);
    chk("mr_next_data", {24'b0, got}, 32'h7E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
